// File: rtl/rs_issue_select.sv
// Registered multi-lane issue selector for the reservation station.
// Picks up to W ready entries per cycle in round-robin or fixed-priority order.
`ifndef RS_SIZE
`define RS_SIZE 8
`endif

module rs_issue_select #(
   parameter int N  = `RS_SIZE,
   parameter int W  = 2,
   parameter bit RR = 1'b1
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           flush,
   input  logic                           stall,
   input  logic [N-1:0]                   ready_vec,
   output logic [W-1:0]                   issue_valid,
   output logic [W-1:0][N-1:0]            grant_oh,
   output logic [W-1:0][$clog2(N)-1:0]    issue_idx
);

   localparam int IW = $clog2(N);

   logic [IW-1:0]         ptr;
   logic [IW-1:0]         ptr_nxt;
   logic [IW-1:0]         base;
   logic [N-1:0]          inflight;
   logic [N-1:0]          cand;
   logic [N-1:0]          rot;
   logic [N-1:0]          remain;
   logic [W-1:0]          sel_valid;
   logic [W-1:0][N-1:0]   sel_oh;
   logic [W-1:0][IW-1:0]  sel_idx;
   logic [IW-1:0]         pos;
   logic [IW-1:0]         entry;
   logic                  found;

   always_comb begin
      inflight  = '0;
      cand      = '0;
      base      = '0;
      rot       = '0;
      remain    = '0;
      sel_valid = '0;
      sel_oh    = '0;
      sel_idx   = '0;
      ptr_nxt   = ptr;
      pos       = '0;
      entry     = '0;
      found     = 1'b0;

      // Entries granted last cycle are cleared by the RS only at this edge.
      for (int unsigned k = 0; k < W; k++) begin
         inflight = inflight | (grant_oh[k] & {N{issue_valid[k]}});
      end
      cand = ready_vec & ~inflight;
      base = RR ? ptr : '0;

      // Rotate so that bit 0 of rot is the first entry in search order.
      for (int unsigned i = 0; i < N; i++) begin
         rot[i] = cand[base + IW'(i)];
      end

      remain = rot;
      for (int unsigned k = 0; k < W; k++) begin
         found = 1'b0;
         pos   = '0;
         for (int unsigned i = 0; i < N; i++) begin
            if (remain[i] && !found) begin
               found = 1'b1;
               pos   = IW'(i);
            end
         end
         if (found) begin
            remain[pos]      = 1'b0;
            entry            = base + pos;
            sel_valid[k]     = 1'b1;
            sel_oh[k][entry] = 1'b1;
            if (RR) begin
               ptr_nxt = entry + IW'(1);
            end
         end
      end

      for (int unsigned k = 0; k < W; k++) begin
         for (int unsigned j = 0; j < N; j++) begin
            if (sel_oh[k][j]) begin
               sel_idx[k] = sel_idx[k] | IW'(j);
            end
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         issue_valid <= '0;
         grant_oh    <= '0;
         issue_idx   <= '0;
         ptr         <= '0;
      end else if (flush) begin
         issue_valid <= '0;
         grant_oh    <= '0;
         issue_idx   <= '0;
         ptr         <= '0;
      end else if (!stall) begin
         issue_valid <= sel_valid;
         grant_oh    <= sel_oh;
         issue_idx   <= sel_idx;
         ptr         <= ptr_nxt;
      end
   end

endmodule

// File: tb/tb_rs_issue_select.sv
// Bench for rs_issue_select: three configurations (W2/RR, W1/RR, W2/fixed) on shared
// inputs, each compared against a list-based reference model.
`timescale 1ns/1ps

module tb_rs_issue_select;

   logic             clock = 1'b0;
   logic             reset = 1'b1;
   logic             flush = 1'b0;
   logic             stall = 1'b0;
   logic [7:0]       ready_vec = '0;

   logic [1:0]       v2;
   logic [1:0][7:0]  go2;
   logic [1:0][2:0]  ix2;
   logic [0:0]       v1;
   logic [0:0][7:0]  go1;
   logic [0:0][2:0]  ix1;
   logic [1:0]       vf;
   logic [1:0][7:0]  gof;
   logic [1:0][2:0]  ixf;

   int vectors = 0;
   int miscompares = 0;

   int m_ptr[3];
   int m_cnt[3];
   int m_g[3][4];

   always #5 clock = ~clock;

   rs_issue_select #(.N(8), .W(2), .RR(1'b1)) dut (
      .clock(clock), .reset(reset), .flush(flush), .stall(stall), .ready_vec(ready_vec),
      .issue_valid(v2), .grant_oh(go2), .issue_idx(ix2));

   rs_issue_select #(.N(8), .W(1), .RR(1'b1)) dut_w1 (
      .clock(clock), .reset(reset), .flush(flush), .stall(stall), .ready_vec(ready_vec),
      .issue_valid(v1), .grant_oh(go1), .issue_idx(ix1));

   rs_issue_select #(.N(8), .W(2), .RR(1'b0)) dut_fp (
      .clock(clock), .reset(reset), .flush(flush), .stall(stall), .ready_vec(ready_vec),
      .issue_valid(vf), .grant_oh(gof), .issue_idx(ixf));

   function automatic int w_of(int s);
      return (s == 1) ? 1 : 2;
   endfunction

   function automatic bit rr_of(int s);
      return (s == 2) ? 1'b0 : 1'b1;
   endfunction

   function automatic logic [3:0] exp_v(int s);
      logic [3:0] r;
      r = '0;
      for (int k = 0; k < m_cnt[s]; k++) r[k] = 1'b1;
      return r;
   endfunction

   function automatic logic [31:0] exp_go(int s);
      logic [31:0] r;
      r = '0;
      for (int k = 0; k < m_cnt[s]; k++) r[k*8 +: 8] = 8'd1 << m_g[s][k];
      return r;
   endfunction

   function automatic logic [11:0] exp_ix(int s);
      logic [11:0] r;
      r = '0;
      for (int k = 0; k < m_cnt[s]; k++) r[k*3 +: 3] = 3'(m_g[s][k]);
      return r;
   endfunction

   task automatic model_reset();
      for (int s = 0; s < 3; s++) begin
         m_ptr[s] = 0;
         m_cnt[s] = 0;
      end
   endtask

   // Walk entries in search order, skipping anything granted last cycle.
   task automatic model_edge(input logic [7:0] rdy, input logic stl, input logic fl);
      for (int s = 0; s < 3; s++) begin
         if (fl) begin
            m_ptr[s] = 0;
            m_cnt[s] = 0;
         end else if (!stl) begin
            bit [7:0] busy;
            int base;
            int n;
            int e;
            int ng[4];
            busy = '0;
            n = 0;
            for (int k = 0; k < m_cnt[s]; k++) busy[m_g[s][k]] = 1'b1;
            base = rr_of(s) ? m_ptr[s] : 0;
            for (int j = 0; j < 8; j++) begin
               e = (base + j) % 8;
               if (rdy[e] && !busy[e] && n < w_of(s)) begin
                  ng[n] = e;
                  n++;
               end
            end
            m_cnt[s] = n;
            for (int k = 0; k < n; k++) m_g[s][k] = ng[k];
            if (rr_of(s) && n > 0) m_ptr[s] = (ng[n-1] + 1) % 8;
         end
      end
   endtask

   task automatic step(input logic [7:0] rdy, input logic stl, input logic fl);
      ready_vec = rdy;
      stall = stl;
      flush = fl;
      @(posedge clock);
      model_edge(rdy, stl, fl);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      ready_vec = 8'hFF;
      repeat (2) @(posedge clock);
      #3 reset = 1'b0;
      model_reset();
      vectors++;
      if (v2 !== 2'b00 || go2 !== 16'h0 || ix2 !== 6'h0) begin
         miscompares++;
         $display("FAIL reset_out: got v=%b g=%h i=%h want 0", v2, go2, ix2);
      end
      vectors++;
      if (dut.ptr !== 3'd0) begin
         miscompares++;
         $display("FAIL reset_ptr: got %0d want 0", dut.ptr);
      end
      step(8'h00, 1'b0, 1'b0);
      vectors++;
      if (v2 !== 2'b00 || v1 !== 1'b0 || vf !== 2'b00) begin
         miscompares++;
         $display("FAIL reset_idle: got %b %b %b want all 0", v2, v1, vf);
      end
   endtask

   task automatic test_basic();
      step(8'b1010_0110, 1'b0, 1'b0);
      vectors++;
      if (v2 !== 2'b11 || go2 !== {8'h04, 8'h02} || ix2 !== {3'd2, 3'd1}) begin
         miscompares++;
         $display("FAIL basic_1: got v=%b g=%h i=%h want v=11 g=0402 i=idx2/idx1", v2, go2, ix2);
      end
      vectors++;
      if (dut.ptr !== 3'd3) begin
         miscompares++;
         $display("FAIL basic_ptr1: got %0d want 3", dut.ptr);
      end
      step(8'b1010_0000, 1'b0, 1'b0);
      vectors++;
      if (v2 !== 2'b11 || go2 !== {8'h80, 8'h20} || ix2 !== {3'd7, 3'd5}) begin
         miscompares++;
         $display("FAIL basic_2: got v=%b g=%h i=%h want v=11 g=8020 i=idx7/idx5", v2, go2, ix2);
      end
      vectors++;
      if (dut.ptr !== 3'd0) begin
         miscompares++;
         $display("FAIL basic_ptr2: got %0d want 0", dut.ptr);
      end
   endtask

   task automatic test_wrap();
      step(8'h00, 1'b0, 1'b0);
      step(8'b0010_0000, 1'b0, 1'b0);
      vectors++;
      if (dut.ptr !== 3'd6) begin
         miscompares++;
         $display("FAIL wrap_setup_ptr: got %0d want 6", dut.ptr);
      end
      step(8'b0100_0001, 1'b0, 1'b0);
      vectors++;
      if (v2 !== 2'b11 || go2 !== {8'h01, 8'h40} || ix2 !== {3'd0, 3'd6}) begin
         miscompares++;
         $display("FAIL wrap_two: got v=%b g=%h i=%h want v=11 g=0140 i=idx0/idx6", v2, go2, ix2);
      end
      vectors++;
      if (dut.ptr !== 3'd1) begin
         miscompares++;
         $display("FAIL wrap_ptr1: got %0d want 1", dut.ptr);
      end
      step(8'h00, 1'b0, 1'b0);
      step(8'b0010_0000, 1'b0, 1'b0);
      step(8'b0100_0000, 1'b0, 1'b0);
      vectors++;
      if (v2 !== 2'b01 || go2 !== {8'h00, 8'h40} || ix2 !== {3'd0, 3'd6}) begin
         miscompares++;
         $display("FAIL wrap_one: got v=%b g=%h i=%h want v=01 g=0040 i=idx6", v2, go2, ix2);
      end
      vectors++;
      if (dut.ptr !== 3'd7) begin
         miscompares++;
         $display("FAIL wrap_ptr7: got %0d want 7", dut.ptr);
      end
   endtask

   task automatic test_stall();
      logic [7:0] r;
      step(8'h00, 1'b0, 1'b0);
      step(8'b0001_0000, 1'b0, 1'b0);
      for (int c = 0; c < 3; c++) begin
         step(8'($urandom), 1'b1, 1'b0);
         vectors++;
         if (v2 !== 2'b01 || go2 !== {8'h00, 8'h10} || ix2 !== {3'd0, 3'd4} || dut.ptr !== 3'd5) begin
            miscompares++;
            $display("FAIL stall_hold%0d: got v=%b g=%h i=%h p=%0d want v=01 g=0010 i=idx4 p=5",
                     c, v2, go2, ix2, dut.ptr);
         end
      end
      r = 8'($urandom) | 8'h10;
      step(r, 1'b0, 1'b0);
      vectors++;
      if (v2 !== 2'(exp_v(0)) || go2 !== 16'(exp_go(0)) || ix2 !== 6'(exp_ix(0))) begin
         miscompares++;
         $display("FAIL stall_release: ready=%h got v=%b g=%h want v=%b g=%h",
                  r, v2, go2, 2'(exp_v(0)), 16'(exp_go(0)));
      end
      vectors++;
      if ((v2[0] && ix2[0] == 3'd4) || (v2[1] && ix2[1] == 3'd4)) begin
         miscompares++;
         $display("FAIL stall_mask4: got i=%h v=%b want no idx4 grant", ix2, v2);
      end
   endtask

   task automatic test_inflight();
      step(8'h00, 1'b0, 1'b0);
      step(8'b0000_1000, 1'b0, 1'b0);
      vectors++;
      if (v1 !== 1'b1 || ix1 !== 3'd3) begin
         miscompares++;
         $display("FAIL inflight_setup: got v=%b i=%0d want v=1 i=3", v1, ix1);
      end
      step(8'b0001_1000, 1'b0, 1'b0);
      vectors++;
      if (v1 !== 1'b1 || go1 !== 8'h10 || ix1 !== 3'd4) begin
         miscompares++;
         $display("FAIL inflight_mask: got v=%b g=%h i=%0d want v=1 g=10 i=4", v1, go1, ix1);
      end
   endtask

   task automatic test_fixed_flush();
      step(8'h00, 1'b0, 1'b0);
      for (int c = 0; c < 4; c++) begin
         step(8'hFF, 1'b0, 1'b0);
         vectors++;
         if (vf !== 2'(exp_v(2)) || gof !== 16'(exp_go(2)) || ixf !== 6'(exp_ix(2))) begin
            miscompares++;
            $display("FAIL fixed_grant%0d: got v=%b g=%h want v=%b g=%h",
                     c, vf, gof, 2'(exp_v(2)), 16'(exp_go(2)));
         end
         vectors++;
         if (dut_fp.ptr !== 3'd0) begin
            miscompares++;
            $display("FAIL fixed_ptr%0d: got %0d want 0", c, dut_fp.ptr);
         end
      end
      step(8'hFF, 1'b1, 1'b1);
      vectors++;
      if (vf !== 2'b00 || gof !== 16'h0 || ixf !== 6'h0 || v2 !== 2'b00 || v1 !== 1'b0) begin
         miscompares++;
         $display("FAIL flush_stall: got vf=%b gf=%h v2=%b v1=%b want 0", vf, gof, v2, v1);
      end
      vectors++;
      if (dut.ptr !== 3'd0 || dut_w1.ptr !== 3'd0) begin
         miscompares++;
         $display("FAIL flush_ptr: got %0d/%0d want 0/0", dut.ptr, dut_w1.ptr);
      end
   endtask

   task automatic test_random();
      logic [7:0] r;
      logic s;
      logic f;
      for (int c = 0; c < 300; c++) begin
         r = 8'($urandom);
         s = ($urandom_range(3) == 0);
         f = ($urandom_range(31) == 0);
         step(r, s, f);
         vectors++;
         if (v2 !== 2'(exp_v(0)) || go2 !== 16'(exp_go(0)) || ix2 !== 6'(exp_ix(0))
             || dut.ptr !== 3'(m_ptr[0])) begin
            miscompares++;
            $display("FAIL rand_w2 c%0d: got v=%b g=%h i=%h p=%0d want v=%b g=%h i=%h p=%0d",
                     c, v2, go2, ix2, dut.ptr, 2'(exp_v(0)), 16'(exp_go(0)), 6'(exp_ix(0)), m_ptr[0]);
         end
         vectors++;
         if (v1 !== 1'(exp_v(1)) || go1 !== 8'(exp_go(1)) || ix1 !== 3'(exp_ix(1))) begin
            miscompares++;
            $display("FAIL rand_w1 c%0d: got v=%b g=%h i=%h want v=%b g=%h i=%h",
                     c, v1, go1, ix1, 1'(exp_v(1)), 8'(exp_go(1)), 3'(exp_ix(1)));
         end
         vectors++;
         if (vf !== 2'(exp_v(2)) || gof !== 16'(exp_go(2)) || ixf !== 6'(exp_ix(2))) begin
            miscompares++;
            $display("FAIL rand_fp c%0d: got v=%b g=%h i=%h want v=%b g=%h i=%h",
                     c, vf, gof, ixf, 2'(exp_v(2)), 16'(exp_go(2)), 6'(exp_ix(2)));
         end
      end
   endtask

   task automatic test_reset_mid();
      step(8'h00, 1'b0, 1'b0);
      step(8'hFF, 1'b0, 1'b0);
      vectors++;
      if (v2 !== 2'b11) begin
         miscompares++;
         $display("FAIL rmid_setup: got v=%b want 11", v2);
      end
      #2 reset = 1'b1;
      #1;
      vectors++;
      if (v2 !== 2'b00 || go2 !== 16'h0 || ix2 !== 6'h0 || v1 !== 1'b0 || vf !== 2'b00) begin
         miscompares++;
         $display("FAIL rmid_async: got v=%b g=%h i=%h v1=%b vf=%b want 0", v2, go2, ix2, v1, vf);
      end
      model_reset();
      #1 reset = 1'b0;
      step(8'h00, 1'b0, 1'b0);
      vectors++;
      if (v2 !== 2'b00 || go2 !== 16'h0 || dut.ptr !== 3'd0) begin
         miscompares++;
         $display("FAIL rmid_after: got v=%b g=%h p=%0d want 0", v2, go2, dut.ptr);
      end
      step(8'b0000_0011, 1'b0, 1'b0);
      vectors++;
      if (v2 !== 2'b11 || ix2 !== {3'd1, 3'd0} || dut.ptr !== 3'd2) begin
         miscompares++;
         $display("FAIL rmid_first: got v=%b i=%h p=%0d want v=11 i=idx1/idx0 p=2", v2, ix2, dut.ptr);
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_basic();
      test_wrap();
      test_stall();
      test_inflight();
      test_fixed_flush();
      test_random();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
